// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared state encoding, default width and magnitude helper for booth_divider_seq
package booth_div_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, FIX, DONE} state_t;
  function automatic logic [63:0] cond_neg(input logic [63:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/booth_divider_seq_div_step.sv
// div_step: one restoring-division iteration on {pr, lo} (ports: pr_i/lo_i/dvs_i in; pr_o, lo_o = lo_i without its MSB, q_o out)
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] pr_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] pr_o,
  output logic [W-2:0] lo_o,
  output logic         q_o
);
  logic [W:0] sh, trial;
  assign sh    = {pr_i, lo_i[W-1]};
  assign trial = sh - {1'b0, dvs_i};
  assign q_o   = ~trial[W];
  assign pr_o  = q_o ? trial[W-1:0] : sh[W-1:0];
  assign lo_o  = lo_i[W-2:0];
endmodule

// File: rtl/booth_divider_seq.sv
// booth_divider_seq: signed 2W/W restoring divider, Start/Ready handshake (ports: clk, Reset_n, Start, Dividend, Divisor in; Quotient, Remainder, Ready, Busy, DivByZero, Overflow out)
module booth_divider_seq import booth_div_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [2*W-1:0] Dividend,
  input  logic [W-1:0]   Divisor,
  output logic [W-1:0]   Quotient,
  output logic [W-1:0]   Remainder,
  output logic           Ready,
  output logic           Busy,
  output logic           DivByZero,
  output logic           Overflow
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sdvd_q, sdvd_d, sdvs_q, sdvs_d;
  logic [W-1:0]   pr_q, pr_d, lo_q, lo_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic           ready_q, ready_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [2*W-1:0] dvd_abs;
  logic [W-1:0]   dvs_abs, pr_nx;
  logic [W-2:0]   lo_nx;
  logic           q_bit, qneg, fix_ovf;
  assign dvd_abs = (2*W)'(cond_neg(64'(Dividend), Dividend[2*W-1]));
  assign dvs_abs = W'(cond_neg(64'(Divisor), Divisor[W-1]));
  assign qneg    = sdvd_q ^ sdvs_q;
  // Magnitude 2^(W-1) is only representable as a negative quotient
  assign fix_ovf = lo_q[W-1] & (~qneg | (|lo_q[W-2:0]));
  div_step #(.W(W)) u_step (
    .pr_i (pr_q),
    .lo_i (lo_q),
    .dvs_i(dvs_q),
    .pr_o (pr_nx),
    .lo_o (lo_nx),
    .q_o  (q_bit)
  );
  // The high half of |Dividend| is parked in pr_q at accept so CHECK can test it directly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sdvd_d  = sdvd_q;
    sdvs_d  = sdvs_q;
    pr_d    = pr_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: if (Start) begin
        sdvd_d  = Dividend[2*W-1];
        sdvs_d  = Divisor[W-1];
        pr_d    = dvd_abs[2*W-1:W];
        lo_d    = dvd_abs[W-1:0];
        dvs_d   = dvs_abs;
        ready_d = 1'b0;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        cnt_d = '0;
        if (dvs_q == '0 || pr_q >= dvs_q) begin
          dbz_d   = dvs_q == '0;
          ovf_d   = dvs_q != '0;
          quo_d   = '0;
          rem_d   = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end else state_d = DIVIDE;
      end
      DIVIDE: begin
        pr_d    = pr_nx;
        lo_d    = {lo_nx, q_bit};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(W-1) ? FIX : DIVIDE;
      end
      FIX: begin
        ovf_d   = fix_ovf;
        quo_d   = fix_ovf ? '0 : W'(cond_neg(64'(lo_q), qneg));
        rem_d   = fix_ovf ? '0 : W'(cond_neg(64'(pr_q), sdvd_q));
        ready_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdvd_q  <= 1'b0;
      sdvs_q  <= 1'b0;
      pr_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdvd_q  <= sdvd_d;
      sdvs_q  <= sdvs_d;
      pr_q    <= pr_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign Ready     = ready_q;
  assign DivByZero = dbz_q;
  assign Overflow  = ovf_q;
  assign Busy      = state_q inside {CHECK, DIVIDE, FIX};
endmodule

// File: tb/tb_booth_divider_seq.sv
// tb_booth_divider_seq: scoreboard bench for booth_divider_seq
module tb_booth_divider_seq;
  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Dividend = '0;
  logic [7:0]  Divisor = '0;
  logic [7:0]  Quotient, Remainder;
  logic        Ready, Busy, DivByZero, Overflow;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } exp_t;
  exp_t sb[$];
  booth_divider_seq #(.W(8)) dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Ready    (Ready),
    .Busy     (Busy),
    .DivByZero(DivByZero),
    .Overflow (Overflow)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [15:0] au, input logic [7:0] bu);
    exp_t e;
    longint a, b, aa, bb, q, r;
    a = longint'($signed(au));
    b = longint'($signed(bu));
    aa = a < 0 ? -a : a;
    bb = b < 0 ? -b : b;
    e.q = '0;
    e.r = '0;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.lat = 10;
    if (b == 0) begin
      e.dz = 1'b1;
      e.lat = 1;
    end else if ((aa >> 8) >= bb) begin
      e.ov = 1'b1;
      e.lat = 1;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 127 || q < -128) e.ov = 1'b1;
      else begin
        e.q = q[7:0];
        e.r = r[7:0];
      end
    end
    return e;
  endfunction
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input bit hold, input bit mid_pulse);
    exp_t e;
    int n;
    @(negedge clk);
    Dividend = a;
    Divisor = b;
    Start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    Start = hold;
    checks++;
    if (Ready !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL accept %h/%h: Ready=%b Busy=%b, want Ready=0 Busy=1", a, b, Ready, Busy);
    end
    n = 0;
    while (Ready !== 1'b1 && n < 40) begin
      if (mid_pulse && n == 3) Start = 1'b1;
      else if (!hold) Start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL latency %h/%h: got %0d edges, want %0d", a, b, n, e.lat);
    end
    checks++;
    if ({Quotient, Remainder, DivByZero, Overflow, Busy} !== {e.q, e.r, e.dz, e.ov, 1'b0}) begin
      errors++;
      $display("FAIL result %h/%h: got Q=%h R=%h dz=%b ov=%b busy=%b, want Q=%h R=%h dz=%b ov=%b busy=0",
               a, b, Quotient, Remainder, DivByZero, Overflow, Busy, e.q, e.r, e.dz, e.ov);
    end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({Quotient, Remainder, Ready, Busy, DivByZero, Overflow} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got Q=%h R=%h rdy=%b busy=%b dz=%b ov=%b, want all 0",
               Quotient, Remainder, Ready, Busy, DivByZero, Overflow);
    end
    #12;
    Reset_n = 1'b1;
  endtask
  task automatic test_signed;
    do_op(16'hD954, 8'h64, 1'b0, 1'b0);
    do_op(16'h0007, 8'hFE, 1'b0, 1'b0);
    do_op(16'hFFF9, 8'h02, 1'b0, 1'b0);
    do_op(16'h0064, 8'h80, 1'b0, 1'b0);
  endtask
  task automatic test_div_by_zero;
    do_op(16'h04D2, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_overflow;
    do_op(16'h4000, 8'h01, 1'b0, 1'b0);
    do_op(16'h0080, 8'h01, 1'b0, 1'b0);
    do_op(16'hFF80, 8'h01, 1'b0, 1'b0);
    do_op(16'h8000, 8'h80, 1'b0, 1'b0);
    do_op(16'h3F80, 8'h80, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    do_op(16'h1234, 8'h3B, 1'b1, 1'b0);
    do_op(16'hEDCC, 8'h3B, 1'b1, 1'b0);
    do_op(16'h0000, 8'h00, 1'b1, 1'b0);
    do_op(16'h0FFF, 8'hE1, 1'b0, 1'b0);
  endtask
  task automatic test_async_reset;
    do_op(16'hD954, 8'h64, 1'b0, 1'b0);
    @(negedge clk);
    Dividend = 16'h1111;
    Divisor = 8'h22;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (Busy !== 1'b1 || Quotient !== 8'h9D) begin
      errors++;
      $display("FAIL mid_op: got busy=%b Q=%h, want busy=1 Q=9d", Busy, Quotient);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Quotient, Remainder, Ready, Busy, DivByZero, Overflow} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: got Q=%h R=%h rdy=%b busy=%b dz=%b ov=%b, want all 0",
               Quotient, Remainder, Ready, Busy, DivByZero, Overflow);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    do_op(16'h0064, 8'hFD, 1'b0, 1'b1);
  endtask
  task automatic test_random;
    logic [15:0] a;
    logic [7:0] b, qq;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      qq = 8'($urandom_range(0, 255));
      a = (i % 3 == 0) ? 16'($urandom_range(0, 65535))
                       : 16'(int'($signed(qq)) * int'($signed(b)) + int'($urandom_range(0, 5)));
      do_op(a, b, 1'b0, 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
